// File: rtl/ttl_parity_pkg.sv
// rtl/ttl_parity_pkg.sv - shared state encoding, clog2 helper and lane-bus slice macro
`ifndef TTL_PARITY_PKG_SV
`define TTL_PARITY_PKG_SV

// Lane idx of a packed 2D lane bus, each lane w bits wide
`define TTL_LANE(bus, idx, w) bus[(idx)*(w) +: (w)]

package ttl_parity_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Counter width for n states, never narrower than one bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`endif

// File: rtl/ttl_parity_accum_if.sv
// rtl/ttl_parity_accum_if.sv - word/control inputs and frame-result outputs of the parity accumulator
interface ttl_parity_accum_if #(
    parameter int BLOCKS       = 4,
    parameter int WIDTH_IN     = 8,
    parameter int ERRCNT_WIDTH = 8
);
    logic                       Valid;
    logic                       Abort;
    logic                       Odd;
    logic [BLOCKS*WIDTH_IN-1:0] A_2D;
    logic [BLOCKS-1:0]          P_in;
    logic [BLOCKS-1:0]          Y;
    logic [BLOCKS-1:0]          Err;
    logic                       Done;
    logic                       Busy;
    logic [ERRCNT_WIDTH-1:0]    Err_count;

    modport master (
        output Valid, Abort, Odd, A_2D, P_in,
        input  Y, Err, Done, Busy, Err_count
    );

    modport slave (
        input  Valid, Abort, Odd, A_2D, P_in,
        output Y, Err, Done, Busy, Err_count
    );
endinterface

// File: rtl/ttl_parity_lane.sv
// rtl/ttl_parity_lane.sv - one parity lane: word XOR reduction plus running frame accumulator
module ttl_parity_lane #(
    parameter int WIDTH_IN = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clear,
    input  logic                last,
    input  logic                odd,
    input  logic [WIDTH_IN-1:0] word,
    output logic                frame_par
);
    logic acc;
    logic word_par;

    assign word_par  = ^word;
    // Parity of the frame if the current word is its last one
    assign frame_par = acc ^ word_par ^ odd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (clear || (en && last)) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ word_par;
        end
    end
endmodule

// File: rtl/ttl_parity_accum.sv
// rtl/ttl_parity_accum.sv - framed multi-lane parity generator/checker; TTL_PARITY_ERRCNT_EN adds error-frame counter
module ttl_parity_accum
    import ttl_parity_pkg::*;
#(
    parameter int BLOCKS       = 4,
    parameter int WIDTH_IN     = 8,
    parameter int FRAME_LEN    = 4,
    parameter int ERRCNT_WIDTH = 8,
    parameter int DELAY_RISE   = 0,
    parameter int DELAY_FALL   = 0
) (
    input  logic               Clk,
    input  logic               Clear_bar,
    ttl_parity_accum_if.slave  bus
);
    localparam int             CNT_W    = clog2_min1(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [BLOCKS-1:0]       frame;
    logic [BLOCKS-1:0]       y_q;
    logic [BLOCKS-1:0]       err_q;
    logic                    done_q;
    logic [ERRCNT_WIDTH-1:0] errcnt_q;
    logic                    last_word;
    logic                    complete;

    assign last_word = (cnt == LAST_CNT);
    assign complete  = bus.Valid && !bus.Abort && last_word;

    for (genvar i = 0; i < BLOCKS; i++) begin : g_lane
        ttl_parity_lane #(.WIDTH_IN(WIDTH_IN)) u_lane (
            .clk       (Clk),
            .rst_n     (Clear_bar),
            .en        (bus.Valid),
            .clear     (bus.Abort),
            .last      (last_word),
            .odd       (bus.Odd),
            .word      (`TTL_LANE(bus.A_2D, i, WIDTH_IN)),
            .frame_par (frame[i])
        );
    end

    // Abort wins over Valid, so an aborted last word never produces Done
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            y_q    <= '0;
            err_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.Abort) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (bus.Valid) begin
                if (last_word) begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    y_q    <= frame;
                    err_q  <= frame ^ bus.P_in;
                    done_q <= 1'b1;
                end else begin
                    state <= ST_ACCUM;
                    cnt   <= cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef TTL_PARITY_ERRCNT_EN
    // Saturating count of completed frames with at least one lane mismatch
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            errcnt_q <= '0;
        end else if (complete && (|(frame ^ bus.P_in)) && (errcnt_q != '1)) begin
            errcnt_q <= errcnt_q + ERRCNT_WIDTH'(1);
        end
    end
`else
    assign errcnt_q = '0;
`endif

    assign #(DELAY_RISE, DELAY_FALL) bus.Y         = y_q;
    assign #(DELAY_RISE, DELAY_FALL) bus.Err       = err_q;
    assign #(DELAY_RISE, DELAY_FALL) bus.Done      = done_q;
    assign #(DELAY_RISE, DELAY_FALL) bus.Busy      = (state == ST_ACCUM);
    assign #(DELAY_RISE, DELAY_FALL) bus.Err_count = errcnt_q;
endmodule
